// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// The slave modport is the unit's view; the master modport is the view of
// the pipeline and data memory that surround it.
interface load_store_unit_if;
  logic        i_Req_Valid;
  logic        o_Req_Ready;
  logic        i_Write;
  logic [1:0]  i_Size;
  logic        i_Unsigned;
  logic [31:0] i_Addr;
  logic [31:0] i_wData;
  logic        o_Resp_Valid;
  logic [31:0] o_rData;
  logic        o_Misaligned;
  logic        o_Mem_wEnable;
  logic [31:0] o_Mem_Addr;
  logic [31:0] o_Mem_wData;
  logic [31:0] i_Mem_rData;

  modport slave (
    input  i_Req_Valid, i_Write, i_Size, i_Unsigned, i_Addr, i_wData, i_Mem_rData,
    output o_Req_Ready, o_Resp_Valid, o_rData, o_Misaligned,
           o_Mem_wEnable, o_Mem_Addr, o_Mem_wData
  );

  modport master (
    output i_Req_Valid, i_Write, i_Size, i_Unsigned, i_Addr, i_wData, i_Mem_rData,
    input  o_Req_Ready, o_Resp_Valid, o_rData, o_Misaligned,
           o_Mem_wEnable, o_Mem_Addr, o_Mem_wData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from the pipeline, talks to
// a word-wide data memory with combinational read data, and returns a
// one-cycle completion pulse carrying the extended load result or a fault.
// Build option: define LSU_SUBWORD_EN to enable byte/half loads and
// read-modify-write byte/half stores. Without it only aligned word accesses
// are legal and every other size takes the fault path.
module load_store_unit (
  input logic              i_Clk,
  input logic              i_Reset,
  load_store_unit_if.slave bus
);

`ifdef LSU_SUBWORD_EN
  typedef enum logic [2:0] {IDLE, ACCESS, READ, WRITE, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  state_t      state_q;
  state_t      state_d;

  logic        req_write_q;
  logic [29:0] req_idx_q;
  logic [31:0] req_wdata_q;
  logic        mis_q;
  logic [31:0] rdata_q;
  logic        req_mis;

`ifdef LSU_SUBWORD_EN
  logic [1:0]  req_size_q;
  logic        req_unsigned_q;
  logic [1:0]  req_lane_q;
  logic [31:0] merge_q;

  // Pick the addressed byte/half lane (little-endian) and extend it.
  function automatic logic [31:0] load_lane(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane,
                                            input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/half lane of the captured memory word.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [15:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = data;
    end else begin
      r[15:0] = data;
    end
    return r;
  endfunction
`endif

  // Classify the presented request as a fault before it is accepted.
  always_comb begin
    req_mis = 1'b0;
`ifdef LSU_SUBWORD_EN
    case (bus.i_Size)
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = bus.i_Addr[0];
      2'b10:   req_mis = |bus.i_Addr[1:0];
      default: req_mis = 1'b1;
    endcase
`else
    req_mis = (bus.i_Size != 2'b10) || (|bus.i_Addr[1:0]);
`endif
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state selection and all bus outputs, decoded from the current state.
  always_comb begin
    state_d           = state_q;
    bus.o_Req_Ready   = 1'b0;
    bus.o_Resp_Valid  = 1'b0;
    bus.o_Misaligned  = 1'b0;
    bus.o_rData       = 32'b0;
    bus.o_Mem_wEnable = 1'b0;
    bus.o_Mem_Addr    = 32'b0;
    bus.o_Mem_wData   = 32'b0;
    case (state_q)
      IDLE: begin
        bus.o_Req_Ready = 1'b1;
        if (bus.i_Req_Valid) begin
`ifdef LSU_SUBWORD_EN
          if (req_mis)                                  state_d = RESP;
          else if (bus.i_Write && bus.i_Size != 2'b10) state_d = READ;
          else                                          state_d = ACCESS;
`else
          if (req_mis) state_d = RESP;
          else         state_d = ACCESS;
`endif
        end
      end
      ACCESS: begin
        bus.o_Mem_Addr = {2'b00, req_idx_q};
        if (req_write_q) begin
          bus.o_Mem_wEnable = 1'b1;
          bus.o_Mem_wData   = req_wdata_q;
        end
        state_d = RESP;
      end
`ifdef LSU_SUBWORD_EN
      READ: begin
        bus.o_Mem_Addr = {2'b00, req_idx_q};
        state_d        = WRITE;
      end
      WRITE: begin
        bus.o_Mem_Addr    = {2'b00, req_idx_q};
        bus.o_Mem_wEnable = 1'b1;
        bus.o_Mem_wData   = merge_lane(merge_q, req_wdata_q[15:0], req_size_q, req_lane_q);
        state_d           = RESP;
      end
`endif
      RESP: begin
        bus.o_Resp_Valid = 1'b1;
        bus.o_Misaligned = mis_q;
        bus.o_rData      = rdata_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, load result and read-modify-write capture register.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      req_write_q    <= 1'b0;
      req_idx_q      <= 30'b0;
      req_wdata_q    <= 32'b0;
      mis_q          <= 1'b0;
      rdata_q        <= 32'b0;
`ifdef LSU_SUBWORD_EN
      req_size_q     <= 2'b0;
      req_unsigned_q <= 1'b0;
      req_lane_q     <= 2'b0;
      merge_q        <= 32'b0;
`endif
    end else begin
      if (state_q == IDLE && bus.i_Req_Valid) begin
        req_write_q    <= bus.i_Write;
        req_idx_q      <= bus.i_Addr[31:2];
        req_wdata_q    <= bus.i_wData;
        mis_q          <= req_mis;
        rdata_q        <= 32'b0;
`ifdef LSU_SUBWORD_EN
        req_size_q     <= bus.i_Size;
        req_unsigned_q <= bus.i_Unsigned;
        req_lane_q     <= bus.i_Addr[1:0];
`endif
      end
      if (state_q == ACCESS && !req_write_q) begin
`ifdef LSU_SUBWORD_EN
        rdata_q <= load_lane(bus.i_Mem_rData, req_size_q, req_lane_q, req_unsigned_q);
`else
        rdata_q <= bus.i_Mem_rData;
`endif
      end
`ifdef LSU_SUBWORD_EN
      if (state_q == READ) merge_q <= bus.i_Mem_rData;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, a reset
// abort sequence and randomized requests against a reference memory model.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_wr_cyc;
    logic [31:0] exp_wr_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  vec_t        vecs    [14];

  load_store_unit_if bus ();

  load_store_unit dut (
    .i_Clk   (clk),
    .i_Reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Data memory with combinational read and clocked write.
  assign bus.i_Mem_rData = mem[bus.o_Mem_Addr[5:0]];
  always @(posedge clk) begin
    if (bus.o_Mem_wEnable) mem[bus.o_Mem_Addr[5:0]] <= bus.o_Mem_wData;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_mis,
                              input int exp_lat, input int exp_wr_cyc,
                              input logic [31:0] exp_wr_data);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_mis = exp_mis; v.exp_lat = exp_lat;
    v.exp_wr_cyc = exp_wr_cyc; v.exp_wr_data = exp_wr_data;
    return v;
  endfunction

  // Reference model: fills in the expected response of v and updates ref_mem.
  task automatic refAccess(inout vec_t v);
    int          nbytes;
    int          off;
    int          idx;
    logic [31:0] word;
    logic [31:0] val;
    logic [31:0] mask;
    bit          fault;
    idx    = int'(v.addr[7:2]);
    off    = int'(v.addr[1:0]);
    nbytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    fault  = (v.size == 2'd3) || ((v.addr & 32'(nbytes - 1)) != 0) || (!SUB && v.size != 2'd2);
    v.exp_rdata = 0; v.exp_wr_cyc = 0; v.exp_wr_data = 0;
    if (fault) begin
      v.exp_mis = 1'b1;
      v.exp_lat = 1;
      return;
    end
    v.exp_mis = 1'b0;
    word = ref_mem[idx];
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (v.wr) begin
      v.exp_wr_data = (word & ~(mask << (8 * off))) | ((v.wdata & mask) << (8 * off));
      ref_mem[idx]  = v.exp_wr_data;
      v.exp_wr_cyc  = (nbytes == 4) ? 1 : 2;
      v.exp_lat     = (nbytes == 4) ? 2 : 3;
    end else begin
      val = (word >> (8 * off)) & mask;
      if (!v.uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
      v.exp_rdata = val;
      v.exp_lat   = 2;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request, scramble the inputs while busy, and check the response.
  task automatic applyStimulus(input vec_t v, input string tag);
    int          w;
    int          lat;
    int          wr_cnt;
    int          wr_cyc;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] r_data;
    logic        r_mis;
    bit          got;
    w = 0; lat = 0; wr_cnt = 0; wr_cyc = 0; wr_addr = 0; wr_data = 0;
    r_data = 0; r_mis = 0; got = 0;
    @(negedge clk);
    while (!bus.o_Req_Ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, " ready"}, 32'(bus.o_Req_Ready), 32'd1);
    bus.i_Req_Valid = 1'b1;
    bus.i_Write     = v.wr;
    bus.i_Size      = v.size;
    bus.i_Unsigned  = v.uns;
    bus.i_Addr      = v.addr;
    bus.i_wData     = v.wdata;
    @(posedge clk);
    #1;
    bus.i_Req_Valid = 1'($urandom_range(0, 1));
    bus.i_Write     = 1'($urandom_range(0, 1));
    bus.i_Size      = 2'($urandom_range(0, 3));
    bus.i_Unsigned  = 1'($urandom_range(0, 1));
    bus.i_Addr      = $urandom;
    bus.i_wData     = $urandom;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (bus.o_Mem_wEnable) begin
        wr_cnt++;
        wr_cyc  = k;
        wr_addr = bus.o_Mem_Addr;
        wr_data = bus.o_Mem_wData;
      end
      if (bus.o_Resp_Valid) begin
        got    = 1;
        lat    = k;
        r_data = bus.o_rData;
        r_mis  = bus.o_Misaligned;
        bus.i_Req_Valid = 1'b0;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s timeout: got no response expected one within 8 cycles", tag);
      bus.i_Req_Valid = 1'b0;
      doReset();
      return;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({tag, " rdata"}, r_data, v.exp_rdata);
    checkOutput({tag, " misaligned"}, 32'(r_mis), 32'(v.exp_mis));
    checkOutput({tag, " write count"}, 32'(wr_cnt), (v.exp_wr_cyc != 0) ? 32'd1 : 32'd0);
    if (v.exp_wr_cyc != 0 && wr_cnt == 1) begin
      checkOutput({tag, " write cycle"}, 32'(wr_cyc), 32'(v.exp_wr_cyc));
      checkOutput({tag, " write addr"}, wr_addr, {2'b00, v.addr[31:2]});
      checkOutput({tag, " write data"}, wr_data, v.exp_wr_data);
    end
    @(negedge clk);
    checkOutput({tag, " ready after resp"}, 32'(bus.o_Req_Ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    vec_t tmp;
    int   k_abort;

    rst_n = 1'b1;
    bus.i_Req_Valid = 1'b0;
    bus.i_Write     = 1'b0;
    bus.i_Size      = 2'b0;
    bus.i_Unsigned  = 1'b0;
    bus.i_Addr      = 32'b0;
    bus.i_wData     = 32'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset resp_valid", 32'(bus.o_Resp_Valid), 32'd0);
    checkOutput("reset misaligned", 32'(bus.o_Misaligned), 32'd0);
    checkOutput("reset rdata", bus.o_rData, 32'd0);
    checkOutput("reset wenable", 32'(bus.o_Mem_wEnable), 32'd0);
    checkOutput("reset mem_addr", bus.o_Mem_Addr, 32'd0);
    checkOutput("reset mem_wdata", bus.o_Mem_wData, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    vecs[0]  = mk(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF);
    vecs[1]  = mk(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0);
    vecs[2]  = mk(1, 2'd2, 0, 32'h10, 32'h8000FF7F, 32'h0, 0, 2, 1, 32'h8000FF7F);
    vecs[3]  = mk(0, 2'd0, 0, 32'h10, 32'h0, SUB ? 32'h0000007F : 32'h0, !SUB, SUB ? 2 : 1, 0, 32'h0);
    vecs[4]  = mk(0, 2'd0, 0, 32'h11, 32'h0, SUB ? 32'hFFFFFFFF : 32'h0, !SUB, SUB ? 2 : 1, 0, 32'h0);
    vecs[5]  = mk(0, 2'd1, 1, 32'h12, 32'h0, SUB ? 32'h00008000 : 32'h0, !SUB, SUB ? 2 : 1, 0, 32'h0);
    vecs[6]  = mk(0, 2'd1, 0, 32'h12, 32'h0, SUB ? 32'hFFFF8000 : 32'h0, !SUB, SUB ? 2 : 1, 0, 32'h0);
    vecs[7]  = mk(0, 2'd2, 0, 32'h13, 32'h0, 32'h0, 1, 1, 0, 32'h0);
    vecs[8]  = mk(0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 32'h0);
    vecs[9]  = mk(1, 2'd2, 0, 32'h10, 32'h11223344, 32'h0, 0, 2, 1, 32'h11223344);
    vecs[10] = mk(1, 2'd0, 0, 32'h12, 32'h5A5A5AAB, 32'h0, !SUB, SUB ? 3 : 1, SUB ? 2 : 0,
                  SUB ? 32'h11AB3344 : 32'h0);
    vecs[11] = mk(0, 2'd2, 0, 32'h10, 32'h0, SUB ? 32'h11AB3344 : 32'h11223344, 0, 2, 0, 32'h0);
    vecs[12] = mk(0, 2'd1, 0, 32'h11, 32'h0, 32'h0, 1, 1, 0, 32'h0);
    vecs[13] = mk(1, 2'd2, 0, 32'h12, 32'hCAFEF00D, 32'h0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 14; i++) begin
      tmp = vecs[i];
      refAccess(tmp);
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted in the write cycle of a store aborts it.
    k_abort = SUB ? 2 : 1;
    @(negedge clk);
    bus.i_Req_Valid = 1'b1;
    bus.i_Write     = 1'b1;
    bus.i_Size      = SUB ? 2'd1 : 2'd2;
    bus.i_Unsigned  = 1'b0;
    bus.i_Addr      = 32'h10;
    bus.i_wData     = 32'h99999999;
    @(posedge clk);
    #1 bus.i_Req_Valid = 1'b0;
    for (int k = 0; k < k_abort; k++) @(negedge clk);
    checkOutput("abort write cycle reached", 32'(bus.o_Mem_wEnable), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort wenable", 32'(bus.o_Mem_wEnable), 32'd0);
    checkOutput("abort resp_valid", 32'(bus.o_Resp_Valid), 32'd0);
    checkOutput("abort mem_addr", bus.o_Mem_Addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("abort ready after release", 32'(bus.o_Req_Ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort late resp", 32'(bus.o_Resp_Valid), 32'd0);
      checkOutput("abort late write", 32'(bus.o_Mem_wEnable), 32'd0);
    end
    v = mk(0, 2'd2, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    refAccess(v);
    applyStimulus(v, "abort readback");

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.wdata = $urandom;
      refAccess(v);
      applyStimulus(v, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
